// File: rtl/irq_pending_reg_pkg.sv
// Shared widths, the reserved line index and the controller state encoding
// for the interrupt pending register.
package irq_pending_reg_pkg;

    localparam int IRQ_W        = 32;
    localparam int IRQ_IDX_W    = 5;
    localparam int IRQ_RESERVED = 0;

    // Line 0 has no valid encoder code, so it is never allowed to pend.
    localparam logic [IRQ_W-1:0] IRQ_LIVE_MASK = ~(IRQ_W'(1) << IRQ_RESERVED);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        SERV = 2'b10
    } irq_state_e;

    // Expand an encoder index into a one-hot line vector.
    function automatic logic [IRQ_W-1:0] irq_onehot(input logic [IRQ_IDX_W-1:0] idx);
        return IRQ_W'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_pending_reg_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchronizer followed by a rising-edge
// or level detector. set_o is the per-cycle "set this pending bit" request.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic async_i,
    output logic set_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous line through the chain; keep last synced value for edge detect.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= synced;
        end
    end

    assign set_o = (EDGE_MODE != 0) ? (synced & ~prev_q) : synced;

endmodule

// File: rtl/irq_pending_reg.sv
// Masked 32-line interrupt pending register with a request/serve/EOI
// handshake towards the CPU control unit. pend_out feeds the external
// priority encoder whose result comes back as ack_idx.
//
//  state | meaning
//  IDLE  | nothing requested; waiting for an enabled pending bit
//  REQ   | irq_req high; waiting for ack (or for pend_out to drain)
//  SERV  | interrupt being serviced; waiting for eoi, no nesting
module irq_pending_reg
    import irq_pending_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [IRQ_W-1:0]     irq_in,
    input  logic                 mask_we,
    input  logic [IRQ_W-1:0]     mask_din,
    output logic [IRQ_W-1:0]     mask_q,
    input  logic                 sw_clr_we,
    input  logic [IRQ_W-1:0]     sw_clr,
    output logic [IRQ_W-1:0]     pend_out,
    output logic                 irq_req,
    input  logic                 ack,
    input  logic [IRQ_IDX_W-1:0] ack_idx,
    input  logic                 eoi,
    output logic                 busy
);

    logic [IRQ_W-1:0] set_vec;
    logic [IRQ_W-1:0] clr_vec;
    logic [IRQ_W-1:0] pend_q;
    logic [IRQ_W-1:0] pend_d;
    irq_state_e       state_q;
    irq_state_e       state_d;
    logic             irq_req_q;
    logic             busy_q;
    logic             unused_irq0;

    assign unused_irq0              = irq_in[IRQ_RESERVED];
    assign set_vec[IRQ_RESERVED]    = 1'b0;

    for (genvar i = 1; i < IRQ_W; i++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_sync_edge (
            .clk     (clk),
            .clr     (clr),
            .async_i (irq_in[i]),
            .set_o   (set_vec[i])
        );
    end

    assign pend_out = pend_q & mask_q & IRQ_LIVE_MASK;

    // Combine the ack and software clear sources; ack only counts while requesting.
    always_comb begin
        clr_vec = '0;
        if (state_q == REQ && ack) begin
            clr_vec = clr_vec | irq_onehot(ack_idx);
        end
        if (sw_clr_we) begin
            clr_vec = clr_vec | sw_clr;
        end
    end

    // A set in the same cycle overrides any clear of that bit.
    assign pend_d = ((pend_q & ~clr_vec) | set_vec) & IRQ_LIVE_MASK;

    // Next-state logic of the request/serve/EOI handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (|pend_out) state_d = REQ;
            REQ: begin
                if (ack)             state_d = SERV;
                else if (~|pend_out) state_d = IDLE;
            end
            SERV: if (eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pending and mask registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (mask_we) mask_q <= mask_din;
        end
    end

    // State plus outputs registered from the next state so they align with it.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            irq_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_req_q <= (state_d == REQ);
            busy_q    <= (state_d == SERV);
        end
    end

    assign irq_req = irq_req_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_irq_pending_reg.sv
module tb_irq_pending_reg;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] irq_in;
    logic        mask_we;
    logic [31:0] mask_din;
    logic [31:0] mask_q;
    logic        sw_clr_we;
    logic [31:0] sw_clr;
    logic [31:0] pend_out;
    logic        irq_req;
    logic        ack;
    logic [4:0]  ack_idx;
    logic        eoi;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // reference model: what the block should hold, from the behavioural rules
    logic [31:0] m_pend, m_mask;
    logic [31:0] m_hist [1:S+1];   // m_hist[k] = irq_in value seen k edges ago
    int          m_mode;           // 0 idle, 1 requesting, 2 serving

    irq_pending_reg #(.SYNC_STAGES(S), .EDGE_MODE(1)) dut (
        .clk(clk), .clr(clr), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
        .mask_q(mask_q), .sw_clr_we(sw_clr_we), .sw_clr(sw_clr), .pend_out(pend_out),
        .irq_req(irq_req), .ack(ack), .ack_idx(ack_idx), .eoi(eoi), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_mode = 0;
        for (int k = 1; k <= S + 1; k++) m_hist[k] = '0;
    endtask

    function automatic logic [31:0] m_visible();
        return m_pend & m_mask & 32'hFFFF_FFFE;
    endfunction

    // One clock: predict the effect of the current inputs, clock, then compare.
    task automatic step();
        logic [31:0] vis, rise, clrv;
        int          nmode;
        vis   = m_visible();
        rise  = m_hist[S] & ~m_hist[S+1];
        clrv  = '0;
        nmode = m_mode;
        if (m_mode == 1 && ack && ack_idx != 0) clrv[ack_idx] = 1'b1;
        if (sw_clr_we) clrv = clrv | sw_clr;
        case (m_mode)
            0: if (vis != 0) nmode = 1;
            1: if (ack) nmode = 2; else if (vis == 0) nmode = 0;
            default: if (eoi) nmode = 0;
        endcase
        @(posedge clk);
        m_pend = ((m_pend & ~clrv) | rise) & 32'hFFFF_FFFE;
        if (mask_we) m_mask = mask_din;
        m_mode = nmode;
        for (int k = S + 1; k >= 2; k--) m_hist[k] = m_hist[k-1];
        m_hist[1] = irq_in & 32'hFFFF_FFFE;
        #1;
        chk("pend_out", pend_out, m_visible());
        chk("irq_req", {31'b0, irq_req}, {31'b0, m_mode == 1});
        chk("busy", {31'b0, busy}, {31'b0, m_mode == 2});
        chk("mask_q", mask_q, m_mask);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] vis;
        clr = 1'b0; irq_in = '0; mask_we = 0; mask_din = '0; sw_clr_we = 0; sw_clr = '0;
        ack = 0; ack_idx = '0; eoi = 0;
        model_reset();
        #1;
        chk("rst_pend_out", pend_out, 32'h0);
        chk("rst_irq_req", {31'b0, irq_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_mask", mask_q, 32'h0);
        #11 clr = 1'b1;

        // full mask, single-cycle pulse on line 5
        mask_we = 1; mask_din = 32'hFFFF_FFFF; step(); mask_we = 0;
        irq_in[5] = 1; step(); irq_in[5] = 0;
        step(); step();
        chk("lat_pend_c3", pend_out, 32'h0000_0020);
        step();
        chk("lat_req_c4", {31'b0, irq_req}, 32'h1);

        // second line, then ack it by index 20
        irq_in[20] = 1; step(); irq_in[20] = 0; steps(2);
        chk("two_pending", pend_out, 32'h0010_0020);
        ack = 1; ack_idx = 5'd20; step(); ack = 0;
        chk("ack20_pend", pend_out, 32'h0000_0020);
        chk("ack20_busy", {31'b0, busy}, 32'h1);
        chk("ack20_req", {31'b0, irq_req}, 32'h0);
        eoi = 1; step(); eoi = 0;
        chk("eoi_idle_busy", {31'b0, busy}, 32'h0);
        step();
        chk("rereq", {31'b0, irq_req}, 32'h1);
        ack = 1; ack_idx = 5'd5; step(); ack = 0;
        eoi = 1; step(); eoi = 0;
        steps(2);

        // masked line latches silently, appears when unmasked
        mask_we = 1; mask_din = 32'h0; step(); mask_we = 0;
        irq_in[9] = 1; step(); irq_in[9] = 0; steps(4);
        chk("masked_pend", pend_out, 32'h0);
        chk("masked_req", {31'b0, irq_req}, 32'h0);
        mask_we = 1; mask_din = 32'h0000_0200; step(); mask_we = 0;
        chk("unmask_pend", pend_out, 32'h0000_0200);
        step();
        chk("unmask_req", {31'b0, irq_req}, 32'h1);
        sw_clr_we = 1; sw_clr = 32'h0000_0200; step(); sw_clr_we = 0;
        step();
        chk("drain_idle", {31'b0, irq_req}, 32'h0);
        mask_we = 1; mask_din = 32'hFFFF_FFFF; step(); mask_we = 0;

        // reserved line 0 never pends
        for (int i = 0; i < 8; i++) begin
            irq_in[0] = ~irq_in[0];
            step();
        end
        irq_in[0] = 0; steps(4);
        chk("line0_pend", pend_out, 32'h0);
        chk("line0_req", {31'b0, irq_req}, 32'h0);

        // set beats a software clear of the same bit
        irq_in[7] = 1; step(); irq_in[7] = 0; steps(4);
        chk("b7_pending", pend_out, 32'h0000_0080);
        irq_in[7] = 1; step(); irq_in[7] = 0; step();
        sw_clr_we = 1; sw_clr = 32'h0000_0080; step(); sw_clr_we = 0;
        chk("set_beats_clr", pend_out, 32'h0000_0080);
        sw_clr_we = 1; step(); sw_clr_we = 0;
        chk("sw_clr_b7", pend_out, 32'h0);
        steps(2);

        // async reset while serving
        irq_in[31] = 1; irq_in[1] = 1; step(); irq_in = '0; steps(3);
        ack = 1; ack_idx = 5'd0; step(); ack = 0;
        chk("serv_pend", pend_out, 32'h8000_0002);
        chk("serv_busy", {31'b0, busy}, 32'h1);
        #2 clr = 1'b0;
        #1;
        model_reset();
        chk("aclr_pend", pend_out, 32'h0);
        chk("aclr_busy", {31'b0, busy}, 32'h0);
        chk("aclr_req", {31'b0, irq_req}, 32'h0);
        chk("aclr_mask", mask_q, 32'h0);
        #3 clr = 1'b1;
        mask_we = 1; mask_din = 32'hFFFF_FFFF; step(); mask_we = 0;
        steps(4);
        chk("post_rst_quiet", {31'b0, irq_req}, 32'h0);
        irq_in[1] = 1; step(); irq_in[1] = 0; steps(3);
        chk("post_rst_rereq", {31'b0, irq_req}, 32'h1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            irq_in    = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            mask_we   = ($urandom_range(0, 15) == 0);
            mask_din  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            sw_clr_we = ($urandom_range(0, 7) == 0);
            sw_clr    = $urandom;
            ack       = ($urandom_range(0, 3) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            ack_idx   = 5'($urandom_range(0, 31));
            vis = m_visible();
            if (vis != 0 && $urandom_range(0, 1) == 0) begin
                for (int b = 31; b >= 1; b--) if (vis[b]) ack_idx = 5'(b);
            end
            step();
        end
        irq_in = '0; mask_we = 0; sw_clr_we = 0; ack = 0; eoi = 0;
        steps(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
